// File: rtl/dffram_pkg.sv
// Shared constants and types for the RAM256 port controller.
package dffram_pkg;

    localparam int DFFRAM_AW      = 8;
    localparam int DFFRAM_DEPTH   = 2 ** DFFRAM_AW;
    localparam int RSP_FIFO_DEPTH = 2;
    localparam int FIFO_CW        = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int FIFO_PW        = $clog2(RSP_FIFO_DEPTH);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/dffram_port_ctrl_if.sv
// Request/response handshake bundle between the cache logic (master)
// and the RAM port controller (slave).
interface dffram_port_ctrl_if
    import dffram_pkg::*;
#(
    parameter int WSIZE = 2,
    parameter int AW    = DFFRAM_AW
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [WSIZE-1:0]     req_wmask;
    logic [AW-1:0]        req_addr;
    logic [WSIZE*8-1:0]   req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WSIZE*8-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dffram_rsp_fifo.sv
// Two-entry read-response FIFO; head is valid whenever count is non-zero.
module dffram_rsp_fifo
    import dffram_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [DW-1:0]      din,
    output logic [FIFO_CW-1:0] count,
    output logic [DW-1:0]      head
);

    logic [DW-1:0]      mem [RSP_FIFO_DEPTH];
    logic [FIFO_PW-1:0] wr_ptr;
    logic [FIFO_PW-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        // NOTE: every register update uses <= so all flops see pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count gates its visibility, so contents after reset are irrelevant.
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/dffram_port_ctrl.sv
// Initiator-side controller for the RAM256 port: request handshake,
// read-response FIFO and a 256-word zero-fill sequencer.
module dffram_port_ctrl
    import dffram_pkg::*;
#(
    parameter int WSIZE = 2,
    parameter int AW    = DFFRAM_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    dffram_port_ctrl_if.slave    bus,
    input  logic                 clear_start,
    output logic                 busy,
    output logic                 ram_en0,
    output logic [WSIZE-1:0]     ram_we0,
    output logic [AW-1:0]        ram_a0,
    output logic [WSIZE*8-1:0]   ram_di0,
    input  logic [WSIZE*8-1:0]   ram_do0
);

    localparam int DW = WSIZE * 8;

    state_t             state;
    logic [AW-1:0]      clr_addr;
    logic               inflight;
    logic [FIFO_CW-1:0] fifo_count;
    logic [DW-1:0]      fifo_head;
    logic               accept;
    logic               pop;
    logic               room;

    // Handshake: a pop this cycle frees a slot for a read issued in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        room          = ({1'b0, fifo_count} + {{FIFO_CW{1'b0}}, inflight}) < (FIFO_CW + 1)'(RSP_FIFO_DEPTH);
        bus.rsp_valid = !rst && (fifo_count != '0);
        pop           = bus.rsp_valid && bus.rsp_ready;
        bus.req_ready = !rst && (state == RUN) && !clear_start && (room || pop);
        accept        = bus.req_valid && bus.req_ready;
        bus.rsp_rdata = fifo_head;
        busy          = rst || (state == CLEAR);
    end

    // Macro port drive: zero-fill while clearing, otherwise the accepted request.
    always_comb begin
        ram_en0 = 1'b0;
        ram_we0 = '0;
        ram_a0  = '0;
        ram_di0 = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                ram_en0 = 1'b1;
                ram_we0 = '1;
                ram_a0  = clr_addr;
            end else if (accept) begin
                ram_en0 = 1'b1;
                ram_a0  = bus.req_addr;
                if (bus.req_we) begin
                    ram_we0 = bus.req_wmask;
                    ram_di0 = bus.req_wdata;
                end
            end
        end
    end

    // Mode sequencing, clear counter and read-in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept && !bus.req_we;
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) state <= RUN;
                end
                RUN: begin
                    if (clear_start) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Read data leaves the macro one cycle after the accept and is queued here.
    dffram_rsp_fifo #(.DW(DW)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (ram_do0),
        .count (fifo_count),
        .head  (fifo_head)
    );

endmodule

// File: doc/dffram_port_ctrl.md
# dffram_port_ctrl

Initiator-side controller for the RAM256 DFFRAM macro port (EN0/WE0/A0/Di0/Do0). It accepts read/write requests on a valid/ready handshake and drives the macro port. Read data returns through a 2-entry response FIFO with backpressure. A hardware clear sequencer zeroes all 256 words after reset and on demand. It sits between the SPI cache fill/lookup logic and the RAM256 instance.

## Interface
Parameters:
- `WSIZE`, 2, bytes per word; data width is WSIZE*8.
- `AW`, 8, address width; depth is 2**AW = 256.

Ports:
- `clk`  in  1  single clock; the RAM CLK uses the same net.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_wmask`  in  WSIZE  per-byte write enable; ignored for reads.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  WSIZE*8  write data.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer pops on `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  WSIZE*8  read data, held stable while `rsp_valid && !rsp_ready`.
- `clear_start`  in  1  request a full zero-fill of the RAM.
- `busy`  out  1  clear in progress.
- `ram_en0`  out  1  to EN0.
- `ram_we0`  out  WSIZE  to WE0.
- `ram_a0`  out  AW  to A0.
- `ram_di0`  out  WSIZE*8  to Di0.
- `ram_do0`  in  WSIZE*8  from Do0.

## Operation
- States: CLEAR and RUN.
- **Reset.** `rst` forces state CLEAR and sets the clear address to 0. It empties the FIFO and clears the in-flight flag.
- **Outputs while `rst` is high.** `req_ready`=0, `rsp_valid`=0, `busy`=1, `ram_en0`=0, `ram_we0`=0, `ram_a0`=0, `ram_di0`=0.
- **CLEAR.** Each cycle drives `ram_en0`=1, `ram_we0`=all ones, `ram_di0`=0, `ram_a0`=clear counter, then increments the counter.
  - After address 255 is written, the next state is RUN. A clear therefore takes exactly 256 cycles.
  - `req_ready`=0 and `busy`=1 throughout. `clear_start` is ignored while in CLEAR.
- **RUN, write accepted.** In the accept cycle: `ram_en0`=1, `ram_we0`=`req_wmask`, `ram_a0`=`req_addr`, `ram_di0`=`req_wdata`. A write produces no response.
- **RUN, read accepted.** In the accept cycle: `ram_en0`=1, `ram_we0`=0, `ram_a0`=`req_addr`. The in-flight flag is set.
  - Next cycle: `ram_do0` is pushed into the FIFO and the in-flight flag is cleared.
- **RUN, no accept.** `ram_en0`=0 and `ram_we0`=0.
- **Ready rule.** `req_ready` = RUN && !`clear_start` && (fifo_count + inflight < 2 || (`rsp_valid` && `rsp_ready`)).
  - This is a combinational path from `rsp_ready` and `clear_start`, and it is intentional.
  - The rule guarantees the FIFO never overflows.
- **Clear entry.** `clear_start`=1 in RUN: no request is accepted that cycle, and the next cycle is CLEAR with address 0.
  - A read in flight at that moment still completes into the FIFO.
  - Queued responses are preserved and may be popped during CLEAR.
- **Ordering.** Responses are returned in request order. A read issued the cycle after a write to the same address returns the new data.

## Timing
- **Read latency.** Accept in cycle N, data captured at the end of N+1, `rsp_valid`=1 from N+2.
- **Throughput.** With `rsp_ready` held at 1, one read per cycle is sustained indefinitely.
- **Write commit.** A write commits at the clock edge ending its accept cycle.
- **First request after reset.** After `rst` deasserts, CLEAR occupies cycles 0..255. `req_ready` can first rise in cycle 256.
- **FIFO.** Simultaneous push and pop in the same cycle is legal, and the count is unchanged. Pop from empty cannot occur.
- **`rst` mid-clear or mid-read.** The clear restarts from address 0, in-flight data is discarded, and the FIFO is emptied.

## Structure
- `dffram_pkg` holds:
  - `DFFRAM_AW` = 8 and `DFFRAM_DEPTH` = 256;
  - the `state_t` enum {CLEAR, RUN};
  - `RSP_FIFO_DEPTH` = 2.
- Sub-module `dffram_rsp_fifo`: a 2-entry synchronous FIFO with push/pop, `count`, and head output. It uses the same `clk`/`rst`.
- The bench instantiates `dffram_port_ctrl` together with RAM256, or RAM256model under Verilator.

## Test plan
- **Reset then clear.** Pulse `rst`, then count cycles until `req_ready`=1 → exactly 256. Read addresses 0, 128 and 255 → each returns 0x0000.
- **Write/read sweep.** Write `i` to address `i` for i=0..255 with wmask=2'b11, then read all back with `rsp_ready`=1 → 256 responses equal to 0x0000..0x00FF, in order, one per cycle after the first.
- **Byte mask.** Write 0xAAAA to address 5, write 0x1234 with wmask=2'b01, then read address 5 → 0xAA34.
- **Backpressure.** With `rsp_ready`=0, issue reads to addresses 1, 2 and 3 → only two are accepted and `req_ready` drops. Raise `rsp_ready` → data 1, 2, 3 returned in order, with no loss or duplication.
- **Clear during traffic.** Write 0x5555 to address 9 and queue a read of address 9, then pulse `clear_start` → the response is 0x5555 and `busy`=1 for 256 cycles. A subsequent read of address 9 returns 0x0000.
- **Reset mid-clear.** Assert `rst` at clear address 100 → `busy` stays 1 and the sequence restarts at `ram_a0`=0. RUN is reached 256 cycles after `rst` deasserts.
